// File: rtl/suhasm_fa_pkg.sv
// Shared constants for the suhasm full-adder tile: ui/uo bit positions, counter width, mode encoding.
package suhasm_fa_pkg;

    localparam int CNT_W    = 4;

    localparam int A_BIT    = 0;
    localparam int B_BIT    = 1;
    localparam int CIN_BIT  = 2;
    localparam int MODE_BIT = 3;
    localparam int CLR_BIT  = 4;

    localparam int SUM_BIT   = 0;
    localparam int COUT_BIT  = 1;
    localparam int CARRY_BIT = 2;
    localparam int VALID_BIT = 3;
    localparam int CNT_LSB   = 4;

    typedef enum logic {
        MODE_PAR = 1'b0,
        MODE_SER = 1'b1
    } mode_e;

endpackage

// File: rtl/suhasm_full_adder_fa_cell.sv
// Purely combinational 1-bit full adder cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/suhasm_full_adder.sv
// Tile top: registered 1-bit full adder with parallel and LSB-first bit-serial modes.
// Optional SUM_HISTORY_EN drives an 8-bit sum history shift register onto uio_out.
module suhasm_full_adder
    import suhasm_fa_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic             sum_q;
    logic             cout_q;
    logic             carry_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    mode_e mode;
    logic  clr;
    logic  ci;
    logic  sum_next;
    logic  cout_next;

    assign mode = mode_e'(ui_in[MODE_BIT]);
    assign clr  = ui_in[CLR_BIT];

    // Serial mode chains the stored carry; clr restarts the stream at bit 0.
    always_comb begin
        ci = ui_in[CIN_BIT];
        if (mode == MODE_SER) begin
            ci = clr ? 1'b0 : carry_q;
        end
    end

    fa_cell u_fa (
        .a  (ui_in[A_BIT]),
        .b  (ui_in[B_BIT]),
        .ci (ci),
        .s  (sum_next),
        .co (cout_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= 1'b0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (ena) begin
            sum_q   <= sum_next;
            cout_q  <= cout_next;
            valid_q <= 1'b1;
            if (mode == MODE_SER) begin
                carry_q <= cout_next;
                cnt_q   <= clr ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end else begin
                carry_q <= 1'b0;
                cnt_q   <= '0;
            end
        end
    end

    assign uo_out[SUM_BIT]   = sum_q;
    assign uo_out[COUT_BIT]  = cout_q;
    assign uo_out[CARRY_BIT] = carry_q;
    assign uo_out[VALID_BIT] = valid_q;

    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_cnt_out
            assign uo_out[CNT_LSB+gi] = cnt_q[gi];
        end
    endgenerate

`ifdef SUM_HISTORY_EN
    logic [7:0] hist_q;

    // Newest sum enters at bit 0, so a finished 8-bit stream reads bit-reversed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else if (ena) begin
            hist_q <= {hist_q[6:0], sum_next};
        end
    end

    assign uio_out = hist_q;
    assign uio_oe  = 8'hFF;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:5], uio_in, 1'b0};

endmodule

// File: tb/tb_suhasm_full_adder.sv
// Directed self-checking bench for suhasm_full_adder (honours SUM_HISTORY_EN when defined).
module tb_suhasm_full_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    suhasm_full_adder dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    // ui_in = {unused[2:0], clr, mode, cin, b, a}
    task automatic step(input logic r, input logic e, input logic [7:0] ui);
        rst   = r;
        ena   = e;
        ui_in = ui;
        uio_in = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ser(input logic clr, input logic b, input logic a);
        return {3'b000, clr, 1'b1, 1'b0, b, a};
    endfunction

    // Expected {cout,sum} for {cin,b,a} = 0..7
    logic [1:0] par_cs [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    // 0xB + 0x6, LSB first
    logic       ser_a  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       ser_b  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ser_uo [4] = '{8'h19, 8'h2E, 8'h3E, 8'h4E};

    initial begin
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [3:0] exp_cnt;

        rst = 1'b1; ena = 1'b1; ui_in = 8'hFF; uio_in = 8'hFF;

        // Reset dominates ena and all inputs
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
`ifdef SUM_HISTORY_EN
        check("reset_uio_oe", uio_oe, 8'hFF);
`else
        check("reset_uio_oe", uio_oe, 8'h00);
`endif

        // Parallel truth table
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(i));
            check($sformatf("par_%0d", i), uo_out, {6'b000010, par_cs[i]});
        end

        // Serial 0xB + 0x6
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, ser(i == 0, ser_b[i], ser_a[i]));
            check($sformatf("ser_b_plus_6_bit%0d", i), uo_out, ser_uo[i]);
        end

        // Hold with ena=0 while toggling operands
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, ser(1'b0, i[0], ~i[0]));
            check($sformatf("hold_%0d", i), uo_out, 8'h4E);
        end
        step(1'b0, 1'b1, ser(1'b0, 1'b0, 1'b0));
        check("resume", uo_out, 8'h59);

        // Build carry, then clr with a=b=0
        step(1'b0, 1'b1, ser(1'b0, 1'b1, 1'b1));
        check("carry_set", uo_out, 8'h6E);
        step(1'b0, 1'b1, ser(1'b1, 1'b0, 1'b0));
        check("clr_with_carry", uo_out, 8'h18);

        // Counter continues 2..15 then wraps to 0
        exp_cnt = 4'd1;
        for (int i = 0; i < 15; i++) begin
            exp_cnt = exp_cnt + 4'd1;
            step(1'b0, 1'b1, ser(1'b0, 1'b0, 1'b0));
            check($sformatf("wrap_%0d", i), uo_out, {exp_cnt, 4'h8});
        end

        // Mode switch 1->0 clears carry; 0->1 without clr starts from carry 0
        step(1'b0, 1'b1, ser(1'b1, 1'b1, 1'b1));
        check("ser_carry1", uo_out, 8'h1E);
        step(1'b0, 1'b1, 8'h00);
        check("switch_to_par", uo_out, 8'h08);
        step(1'b0, 1'b1, ser(1'b0, 1'b0, 1'b1));
        check("switch_to_ser", uo_out, 8'h19);

        // clr and upper ui bits ignored in parallel mode
        step(1'b0, 1'b1, 8'b000_1_0_111);
        check("par_clr_ignored", uo_out, 8'h0B);
        step(1'b0, 1'b1, 8'b111_0_0_001);
        check("par_unused_bits", uo_out, 8'h09);

        // Reset mid-stream discards carry and count
        step(1'b0, 1'b1, ser(1'b1, 1'b1, 1'b1));
        check("pre_reset_carry", uo_out, 8'h1E);
        step(1'b1, 1'b0, ser(1'b0, 1'b1, 1'b1));
        check("mid_reset", uo_out, 8'h00);
        step(1'b0, 1'b1, ser(1'b0, 1'b0, 1'b1));
        check("post_reset_ser", uo_out, 8'h19);

        // 8-bit serial add 0x5A + 0x3C = 0x96
        op_a = 8'h5A;
        op_b = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, ser(i == 0, op_b[i], op_a[i]));
        end
        check("add8_uo", uo_out, 8'h89);
`ifdef SUM_HISTORY_EN
        check("add8_hist", uio_out, 8'h69);
        check("add8_oe", uio_oe, 8'hFF);
`else
        check("add8_uio_out", uio_out, 8'h00);
        check("add8_uio_oe", uio_oe, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
